// File: rtl/weight_buffer.sv
// Weight buffer: DEPTH-word register file that streams LANES-wide weight vectors
// in row or column order, with a ready/valid output register and 1-cycle read latency.
module weight_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_mode,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [ADDR_W-1:0]       cmd_stride,
    input  logic [CNT_W-1:0]        cmd_count,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   stride_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    idx_q;
    logic                zero_done;

    logic                issue;
    logic                last_issue;
    logic [ADDR_W-1:0]   lane_stride;
    logic [ADDR_W-1:0]   next_base;
    logic [ADDR_W-1:0]   lane_addr [LANES];
    logic [LANES*DATA_W-1:0] rd_vec;

    assign cmd_ready   = (state == IDLE);
    assign issue       = (state == RUN) && (!out_valid || out_ready);
    assign last_issue  = (idx_q == count_q - CNT_W'(1));
    assign lane_stride = mode_q ? stride_q : ADDR_W'(1);
    assign next_base   = mode_q ? base_q + ADDR_W'(1) : base_q + ADDR_W'(LANES);

    // done fires in the handshake cycle of the last vector, or one cycle after a zero-count command.
    assign done = zero_done | (out_valid & out_ready & out_last);

    // Address sums wrap naturally at ADDR_W bits, giving the modulo-DEPTH behaviour.
    always_comb begin
        rd_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = base_q + ADDR_W'(i) * lane_stride;
            rd_vec[i*DATA_W +: DATA_W] = mem[lane_addr[i]];
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM/flops without a reset tree;
    // reads in the same edge see the pre-write value because both sides use non-blocking updates.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            zero_done <= 1'b0;
            mode_q    <= 1'b0;
            base_q    <= '0;
            stride_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_count == '0) begin
                            zero_done <= 1'b1;
                        end else begin
                            mode_q   <= cmd_mode;
                            base_q   <= cmd_addr;
                            stride_q <= cmd_stride;
                            count_q  <= cmd_count;
                            idx_q    <= '0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        idx_q  <= idx_q + CNT_W'(1);
                        base_q <= next_base;
                        if (last_issue) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                out_valid <= 1'b1;
                out_data  <= rd_vec;
                out_last  <= last_issue;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_buffer.sv
// Self-checking bench for weight_buffer: directed vectors, corner sequences and a
// randomized phase scored against a queue-based reference model.
module tb_weight_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int LANES  = 4;
    localparam int CNT_W  = 8;
    localparam int ADDR_W = 5;
    localparam int OUT_W  = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_mode;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_stride;
    logic [CNT_W-1:0]  cmd_count;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              done;

    weight_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_addr(cmd_addr), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    typedef struct {
        logic             mode;
        int               addr;
        int               stride;
        logic [OUT_W-1:0] exp;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          model_mem [DEPTH];
    exp_t        exp_q [$];
    logic        mon_en = 1'b0;
    logic        rand_ready = 1'b0;
    logic        zero_ok = 1'b0;
    logic        seen_ready;
    logic        prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_data;
    logic        prev_last;
    int          hs_count = 0;
    int          stray_done = 0;
    vec_t        tbl [7];

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within its bound", name);
    endtask

    function automatic logic [OUT_W-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
    endfunction

    // Reference: every vector of a burst computed straight from the addressing rules.
    task automatic push_model(input logic m, input int a, input int s, input int c);
        for (int v = 0; v < c; v++) begin
            exp_t e;
            int   base;
            base = (a + v * (m ? 1 : LANES)) % DEPTH;
            for (int i = 0; i < LANES; i++)
                e.data[i*DATA_W +: DATA_W] = DATA_W'(model_mem[(base + i * (m ? s : 1)) % DEPTH]);
            e.last = (v == c - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        if (prev_stall) begin
            check("hold_valid", OUT_W'(out_valid), OUT_W'(1));
            check("hold_data", out_data, prev_data);
            check("hold_last", OUT_W'(out_last), OUT_W'(prev_last));
        end
        if (out_valid && out_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                flag("unexpected_vector");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("vec_data", out_data, e.data);
                check("vec_last", OUT_W'(out_last), OUT_W'(e.last));
                check("done_on_hs", OUT_W'(done), OUT_W'(e.last));
            end
        end else if (done && !zero_ok) begin
            stray_done++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    task automatic tick();
        @(negedge clk);
        seen_ready = cmd_ready;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic write_word(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = DATA_W'(d);
        model_mem[a] = d & 16'hFFFF;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic m, input int a, input int s, input int c);
        logic acc;
        acc        = 1'b0;
        cmd_valid  = 1'b1;
        cmd_mode   = m;
        cmd_addr   = ADDR_W'(a);
        cmd_stride = ADDR_W'(s);
        cmd_count  = CNT_W'(c);
        for (int n = 0; n < 100 && !acc; n++) begin
            tick();
            if (seen_ready) acc = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!acc) flag("cmd_accept");
        else push_model(m, a, s, c);
    endtask

    task automatic wait_valid();
        logic got;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            if (out_valid) got = 1'b1;
            else tick();
        end
        if (!got) flag("wait_valid");
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int n = 0; n < 400 && !empty; n++) begin
            if (exp_q.size() == 0 && !out_valid) empty = 1'b1;
            else tick();
        end
        if (!empty) flag("drain");
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        int h0;

        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_addr = '0; cmd_stride = '0; cmd_count = '0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", OUT_W'(out_valid), OUT_W'(0));
        check("rst_last", OUT_W'(out_last), OUT_W'(0));
        check("rst_done", OUT_W'(done), OUT_W'(0));
        check("rst_data", out_data, OUT_W'(0));
        reset = 1'b1;
        mon_en = 1'b1;
        tick();
        check("rst_cmd_ready", OUT_W'(cmd_ready), OUT_W'(1));

        for (int k = 0; k < DEPTH; k++) write_word(k, 10 + k);

        // Row burst of two vectors at full throughput
        send_cmd(1'b0, 0, 0, 2);
        wait_valid();
        check("row_v0", out_data, pack4(10, 11, 12, 13));
        check("row_v0_last", OUT_W'(out_last), OUT_W'(0));
        check("row_v0_done", OUT_W'(done), OUT_W'(0));
        check("row_v0_busy", OUT_W'(cmd_ready), OUT_W'(0));
        tick();
        check("row_v1_valid", OUT_W'(out_valid), OUT_W'(1));
        check("row_v1", out_data, pack4(14, 15, 16, 17));
        check("row_v1_last", OUT_W'(out_last), OUT_W'(1));
        check("row_v1_done", OUT_W'(done), OUT_W'(1));
        check("row_v1_idle", OUT_W'(cmd_ready), OUT_W'(1));
        tick();
        check("row_end_valid", OUT_W'(out_valid), OUT_W'(0));

        // Single-vector addressing table (memory word k holds 10+k)
        tbl[0] = '{1'b0, 0,  0,  pack4(10, 11, 12, 13)};
        tbl[1] = '{1'b0, 30, 0,  pack4(40, 41, 10, 11)};
        tbl[2] = '{1'b1, 2,  3,  pack4(12, 15, 18, 21)};
        tbl[3] = '{1'b1, 20, 5,  pack4(30, 35, 40, 13)};
        tbl[4] = '{1'b1, 7,  0,  pack4(17, 17, 17, 17)};
        tbl[5] = '{1'b1, 1,  31, pack4(11, 10, 41, 40)};
        tbl[6] = '{1'b0, 29, 9,  pack4(39, 40, 41, 10)};
        for (int t = 0; t < 7; t++) begin
            send_cmd(tbl[t].mode, tbl[t].addr, tbl[t].stride, 1);
            wait_valid();
            check($sformatf("tbl%0d_data", t), out_data, tbl[t].exp);
            check($sformatf("tbl%0d_last", t), OUT_W'(out_last), OUT_W'(1));
            drain();
        end

        // Column mode with wrap-around
        write_word(30, 3); write_word(31, 5); write_word(0, 4); write_word(1, 6);
        send_cmd(1'b1, 30, 1, 1);
        wait_valid();
        check("col_wrap", out_data, pack4(3, 5, 4, 6));
        drain();
        send_cmd(1'b1, 15, 8, 2);
        wait_valid();
        check("col_s8_v0", out_data, pack4(25, 33, 5, 17));
        tick();
        check("col_s8_v1", out_data, pack4(26, 34, 4, 18));
        drain();

        // Backpressure for three cycles mid-burst
        h0 = hs_count;
        send_cmd(1'b0, 8, 0, 4);
        wait_valid();
        tick();
        out_ready = 1'b0;
        held = out_data;
        repeat (3) tick();
        check("bp_held", out_data, held);
        check("bp_vec1", out_data, pack4(22, 23, 24, 25));
        out_ready = 1'b1;
        drain();
        check("bp_count", OUT_W'(hs_count - h0), OUT_W'(4));

        // Same-edge write and read of word 4
        send_cmd(1'b0, 4, 0, 1);
        wr_en = 1'b1; wr_addr = ADDR_W'(4); wr_data = DATA_W'(99);
        model_mem[4] = 99;
        tick();
        wr_en = 1'b0;
        check("coll_old", OUT_W'(out_data[DATA_W-1:0]), OUT_W'(14));
        drain();
        send_cmd(1'b0, 4, 0, 1);
        wait_valid();
        check("coll_new", OUT_W'(out_data[DATA_W-1:0]), OUT_W'(99));
        drain();

        // Zero-count command
        zero_ok = 1'b1;
        send_cmd(1'b0, 0, 0, 0);
        check("zero_done", OUT_W'(done), OUT_W'(1));
        check("zero_ready", OUT_W'(cmd_ready), OUT_W'(1));
        check("zero_valid", OUT_W'(out_valid), OUT_W'(0));
        tick();
        check("zero_done_end", OUT_W'(done), OUT_W'(0));
        check("zero_valid_end", OUT_W'(out_valid), OUT_W'(0));
        zero_ok = 1'b0;

        // Reset after two vectors of a four-vector burst
        h0 = hs_count;
        send_cmd(1'b0, 0, 0, 4);
        for (int n = 0; n < 20 && hs_count < h0 + 2; n++) tick();
        if (hs_count < h0 + 2) flag("mid_burst_wait");
        #2 reset = 1'b0;
        #1;
        check("mrst_valid", OUT_W'(out_valid), OUT_W'(0));
        check("mrst_done", OUT_W'(done), OUT_W'(0));
        check("mrst_data", out_data, OUT_W'(0));
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mrst_idle", OUT_W'(cmd_ready), OUT_W'(1));
        check("mrst_no_vec", OUT_W'(out_valid), OUT_W'(0));
        send_cmd(1'b0, 8, 0, 1);
        wait_valid();
        check("mrst_mem", out_data, pack4(18, 19, 20, 21));
        drain();

        // Randomized bursts, writes only while idle, random consumer stalls
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                drain();
                repeat (3) write_word($urandom_range(0, DEPTH - 1), $urandom_range(0, 65535));
            end
            send_cmd(1'(($urandom_range(0, 1))), $urandom_range(0, DEPTH - 1),
                     $urandom_range(0, DEPTH - 1), $urandom_range(1, 6));
        end
        drain();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

        check("stray_done", OUT_W'(stray_done), OUT_W'(0));
        check("queue_empty", OUT_W'(exp_q.size()), OUT_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_buffer.md
WEIGHT_BUFFER -- requirements
Module: weight_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, weight word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of words stored (power of two, >= LANES).
REQ-003 SHALL have parameter LANES, default 4, weights delivered per output vector.
REQ-004 SHALL have parameter CNT_W, default 8, width of the burst vector count; ADDR_W = clog2(DEPTH).
REQ-005 SHALL have ports as listed:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_W  write word.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  burst command accepted when both cmd_valid and cmd_ready are high.
- cmd_mode  in  1  0 = row (lane stride 1), 1 = column (lane stride cmd_stride).
- cmd_addr  in  ADDR_W  base address of first vector.
- cmd_stride  in  ADDR_W  lane stride in column mode; ignored in row mode.
- cmd_count  in  CNT_W  number of vectors in burst.
- out_valid  out  1  output vector valid.
- out_ready  in  1  consumer accepts vector.
- out_data  out  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W].
- out_last  out  1  marks final vector of burst.
- done  out  1  one-cycle pulse on the last vector handshake.

Function
REQ-006 SHALL store DEPTH words of DATA_W bits; a write with wr_en=1 updates word wr_addr at the clock edge, in any state.
REQ-007 SHALL be in one of two states, IDLE or RUN; cmd_ready SHALL be 1 only in IDLE.
REQ-008 On command accept, SHALL latch mode, addr, stride, and count, then enter RUN.
REQ-008a If cmd_count = 0, SHALL instead stay in IDLE, produce no vectors, and pulse done the next cycle.
REQ-009 Lane i of a vector with base b SHALL read word (b + i*s) mod DEPTH, where s = 1 in row mode and s = cmd_stride in column mode.
REQ-010 Successive vector bases SHALL advance by LANES in row mode and by 1 in column mode, modulo DEPTH (wrap-around, no error).
REQ-011 In RUN, SHALL issue one vector read per cycle whenever the output register is empty or is being emptied this cycle (out_valid & out_ready).
REQ-011a Data SHALL appear on out_data with out_valid=1 the cycle after issue, giving 1-cycle read latency and full throughput of one vector per cycle when out_ready=1.
REQ-012 While out_valid=1 and out_ready=0, out_data, out_last, and out_valid SHALL hold stable, and no new read SHALL issue.
REQ-013 out_last SHALL be 1 exactly on the vector whose index = count-1.
REQ-013a The state SHALL return to IDLE in the cycle after the last vector is issued.
REQ-013b A new command MAY be accepted while the last vector still waits on out_ready; its first vector SHALL not issue until the output register frees.
REQ-014 done SHALL pulse for exactly one cycle, in the cycle the out_last vector handshakes.
REQ-015 Read/write collision on the same word in the same cycle SHALL return the old (pre-write) value; a write issued one or more cycles before the read issue SHALL be visible.
REQ-016 Address arithmetic SHALL be performed at ADDR_W bits with truncation; the count SHALL be unsigned CNT_W.

Reset
REQ-017 While reset=0, the block SHALL asynchronously force state=IDLE, out_valid=0, out_last=0, done=0, and out_data=0, with cmd_ready=1 once reset is released.
REQ-018 Reset mid-burst SHALL abandon the burst with no further vectors and no done pulse.
REQ-019 Reset SHALL NOT alter memory contents; contents after power-up are undefined until written.

Verification
REQ-020 Row burst: write words 0..7 = 10..17; cmd row, addr 0, count 2, out_ready=1.
- Vectors {10,11,12,13} then {14,15,16,17} on consecutive cycles, first one cycle after accept.
- out_last and done on the second vector.
REQ-021 Column with wrap: DEPTH=32, words 30,31,0,1 = 3,5,4,6; cmd column, addr 30, stride 1, count 1.
- out_data = {3,5,4,6}.
- Column, addr 15, stride 8, count 2 reads lanes 15,23,31,7 then 16,24,0,8.
REQ-022 Backpressure: out_ready=0 for 3 cycles mid-burst.
- Output held stable.
- No vector lost or duplicated.
- Order preserved.
REQ-023 Collision: write word 4 = 99 in the same cycle vector base 4 (row) issues.
- Lane 0 returns the old value.
- A later burst returns 99.
REQ-024 Zero count: cmd count=0.
- No out_valid.
- done pulses once the next cycle.
- cmd_ready stays 1.
REQ-025 Reset mid-burst: assert reset during a count-4 burst after 2 vectors.
- out_valid=0 immediately.
- No done pulse.
- Memory unchanged.
- A new burst after release reads the stored values.
